// File: rtl/sat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sat_pkg
//  Description : Shared number formats, object record, FSM state encoding and
//                helpers for the SAT collision engine.
//                Positions are signed Q7.25, basis vectors signed Q2.14 and
//                the projection/radius comparison is done in Q25.39 (64 bit).
//  Revision    : 1.0  initial release
// ============================================================================
package sat_pkg;

  localparam int POS_INT    = 7;
  localparam int POS_FRAC   = 25;
  localparam int BASIS_FRAC = 14;
  localparam int CMP_FRAC   = 39;
  localparam int CMP_W      = 64;

  localparam int POS_W      = POS_INT + POS_FRAC;      // 32
  localparam int BASIS_W    = 2 + BASIS_FRAC;          // 16
  // Basis dot products come out at 2*BASIS_FRAC fraction bits; the radius
  // is shifted up to the projection's CMP_FRAC fraction bits.
  localparam int RAD_SHIFT  = CMP_FRAC - 2 * BASIS_FRAC;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pos_t;

  typedef struct packed {
    logic [BASIS_W-1:0] x;
    logic [BASIS_W-1:0] y;
  } vec_t;

  typedef struct packed {
    logic       active;
    logic [7:0] width;
    logic [7:0] height;
    pos_t       pos;
    vec_t       u;
    vec_t       v;
  } obj_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_AXIS  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Linear index of unordered pair (i<j): (0,1),(0,2)..(0,n-1),(1,2)..
  function automatic int pair_index(input int i, input int j, input int n);
    return i * (2 * n - i - 1) / 2 + (j - i - 1);
  endfunction

  // |p.q| of two Q2.14 vectors, result in Q4.28 (unsigned magnitude).
  function automatic logic [2*BASIS_W:0] abs_dot(input vec_t p, input vec_t q);
    logic signed [2*BASIS_W:0] s;
    s = $signed(p.x) * $signed(q.x) + $signed(p.y) * $signed(q.y);
    return s[2*BASIS_W] ? -s : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_axis_test.sv
`default_nettype none
// ============================================================================
//  Module      : sat_axis_test
//  Description : Combinational single-axis SAT test for two oriented
//                rectangles. Projects the centre distance and both boxes'
//                half-extents onto the selected axis and reports separation.
//  Ports       : i_a, i_b       rectangle records
//                i_k            axis select: 0=uA 1=vA 2=uB 3=vB
//                o_separated    1 when the axis separates the pair
//                o_proj, o_rad  Q25.39 projection / radius (debug)
//  Revision    : 1.0  initial release
// ============================================================================
module sat_axis_test
  import sat_pkg::*;
(
  input  obj_t             i_a,
  input  obj_t             i_b,
  input  logic [1:0]       i_k,
  output logic             o_separated,
  output logic [CMP_W-1:0] o_proj,
  output logic [CMP_W-1:0] o_rad
);

  localparam int DOT_W  = 2 * BASIS_W + 1;   // Q4.28 magnitude
  localparam int PRJ_W  = POS_W + BASIS_W + 2; // |Q9.39| with headroom
  localparam int RAD_W  = 7 + DOT_W + 2;     // sum of four 7b x DOT_W terms

  vec_t w_l;

  always_comb begin
    case (i_k)
      2'd0:    w_l = i_a.u;
      2'd1:    w_l = i_a.v;
      2'd2:    w_l = i_b.u;
      default: w_l = i_b.v;
    endcase
  end

  // Centre difference gets one extra bit so opposite-extreme positions
  // cannot wrap.
  logic signed [POS_W:0]         w_dx, w_dy;
  logic signed [POS_W+BASIS_W:0] w_px, w_py;
  logic signed [PRJ_W-1:0]       w_dsum;
  logic        [PRJ_W-1:0]       w_proj_mag;
  logic        [RAD_W-1:0]       w_rad28;

  assign w_dx = {i_a.pos.x[POS_W-1], i_a.pos.x} - {i_b.pos.x[POS_W-1], i_b.pos.x};
  assign w_dy = {i_a.pos.y[POS_W-1], i_a.pos.y} - {i_b.pos.y[POS_W-1], i_b.pos.y};
  assign w_px = w_dx * $signed(w_l.x);
  assign w_py = w_dy * $signed(w_l.y);
  assign w_dsum     = w_px + w_py;
  assign w_proj_mag = w_dsum[PRJ_W-1] ? -w_dsum : w_dsum;

  // Half extents are width>>1 / height>>1, so bit 0 of each size is dropped.
  assign w_rad28 = RAD_W'(i_a.width[7:1])  * RAD_W'(abs_dot(i_a.u, w_l))
                 + RAD_W'(i_a.height[7:1]) * RAD_W'(abs_dot(i_a.v, w_l))
                 + RAD_W'(i_b.width[7:1])  * RAD_W'(abs_dot(i_b.u, w_l))
                 + RAD_W'(i_b.height[7:1]) * RAD_W'(abs_dot(i_b.v, w_l));

  assign o_proj = CMP_W'(w_proj_mag);
  assign o_rad  = CMP_W'(w_rad28) << RAD_SHIFT;

  // Touching (proj == rad) counts as separated. An inactive operand can
  // never collide.
  assign o_separated = !(i_a.active && i_b.active) || (o_proj >= o_rad);

endmodule
`default_nettype wire

// File: rtl/sat_collision_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sat_collision_engine
//  Description : Sequential SAT collision engine. Holds NUM_OBJ oriented
//                rectangles, scans every pair (i<j) on start testing one axis
//                per cycle with early exit, and reports per-pair, per-object
//                and global hit flags.
//  Ports       : clk, reset_n       clock, async active-low reset
//                start/busy/done    scan handshake
//                obj_wr_*           object table write port (idle only)
//                pair_hit           one bit per pair, held until next start
//                obj_hit, any_hit   OR reductions of pair_hit
//  Revision    : 1.0  initial release
// ============================================================================
module sat_collision_engine
  import sat_pkg::*;
#(
  parameter int NUM_OBJ   = 4,
  parameter int IDX_W     = $clog2(NUM_OBJ),
  parameter int NUM_PAIRS = NUM_OBJ * (NUM_OBJ - 1) / 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 obj_wr_en,
  input  logic [IDX_W-1:0]     obj_wr_idx,
  input  logic                 obj_wr_active,
  input  logic [7:0]           obj_wr_width,
  input  logic [7:0]           obj_wr_height,
  input  logic [POS_W-1:0]     obj_wr_pos_x,
  input  logic [POS_W-1:0]     obj_wr_pos_y,
  input  logic [BASIS_W-1:0]   obj_wr_u_x,
  input  logic [BASIS_W-1:0]   obj_wr_u_y,
  input  logic [BASIS_W-1:0]   obj_wr_v_x,
  input  logic [BASIS_W-1:0]   obj_wr_v_y,
  output logic [NUM_PAIRS-1:0] pair_hit,
  output logic [NUM_OBJ-1:0]   obj_hit,
  output logic                 any_hit
);

  state_t               r_state, w_next;
  obj_t                 r_tab [NUM_OBJ];
  obj_t                 r_a, r_b, w_wr_entry;
  logic [IDX_W-1:0]     r_i, r_j;
  logic [1:0]           r_k;
  logic                 r_result;
  logic [NUM_PAIRS-1:0] r_pair_hit, w_pair_sel;
  logic [NUM_OBJ-1:0]   w_adj [NUM_OBJ];
  logic                 w_wr_ok, w_pair_live, w_last_pair, w_sep;
  logic [CMP_W-1:0]     w_dbg_proj, w_dbg_rad;

  assign w_wr_ok     = obj_wr_en && (r_state == S_IDLE) && (32'(obj_wr_idx) < NUM_OBJ);
  assign w_pair_live = r_tab[r_i].active && r_tab[r_j].active;
  assign w_last_pair = (r_i == IDX_W'(NUM_OBJ - 2)) && (r_j == IDX_W'(NUM_OBJ - 1));

  always_comb begin
    w_wr_entry         = '0;
    w_wr_entry.active  = obj_wr_active;
    w_wr_entry.width   = obj_wr_width;
    w_wr_entry.height  = obj_wr_height;
    w_wr_entry.pos.x   = obj_wr_pos_x;
    w_wr_entry.pos.y   = obj_wr_pos_y;
    w_wr_entry.u.x     = obj_wr_u_x;
    w_wr_entry.u.y     = obj_wr_u_y;
    w_wr_entry.v.x     = obj_wr_v_x;
    w_wr_entry.v.y     = obj_wr_v_y;
  end

  sat_axis_test u_axis (
    .i_a         (r_a),
    .i_b         (r_b),
    .i_k         (r_k),
    .o_separated (w_sep),
    .o_proj      (w_dbg_proj),
    .o_rad       (w_dbg_rad)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FETCH;
      end
      // An inactive pair is resolved in FETCH alone.
      S_FETCH: begin
        if (!w_pair_live) w_next = w_last_pair ? S_FIN : S_FETCH;
        else              w_next = S_AXIS;
      end
      S_AXIS:  if (w_sep || r_k == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = w_last_pair ? S_FIN : S_FETCH;
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= 1'b0;
      r_pair_hit <= '0;
      for (int n = 0; n < NUM_OBJ; n++) r_tab[n] <= '0;
    end else begin
      if (w_wr_ok) r_tab[obj_wr_idx] <= w_wr_entry;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pair_hit <= '0;
            r_i        <= '0;
            r_j        <= IDX_W'(1);
          end
        end
        S_FETCH: begin
          r_a <= r_tab[r_i];
          r_b <= r_tab[r_j];
          r_k <= '0;
          if (!w_pair_live) begin
            r_pair_hit <= r_pair_hit & ~w_pair_sel;
            if (r_j == IDX_W'(NUM_OBJ - 1)) begin
              r_i <= r_i + IDX_W'(1);
              r_j <= r_i + IDX_W'(2);
            end else begin
              r_j <= r_j + IDX_W'(1);
            end
          end
        end
        S_AXIS: begin
          if (w_sep)              r_result <= 1'b0;
          else if (r_k == 2'd3)   r_result <= 1'b1;
          else                    r_k      <= r_k + 2'd1;
        end
        S_WRITE: begin
          r_pair_hit <= (r_pair_hit & ~w_pair_sel) | (w_pair_sel & {NUM_PAIRS{r_result}});
          if (r_j == IDX_W'(NUM_OBJ - 1)) begin
            r_i <= r_i + IDX_W'(1);
            r_j <= r_i + IDX_W'(2);
          end else begin
            r_j <= r_j + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------ pair select and hit reductions
  // w_adj is the symmetric object adjacency matrix built from pair_hit.
  for (genvar ga = 0; ga < NUM_OBJ; ga++) begin : g_row
    for (genvar gb = 0; gb < NUM_OBJ; gb++) begin : g_col
      if (ga < gb) begin : g_upper
        localparam int P = pair_index(ga, gb, NUM_OBJ);
        assign w_pair_sel[P]  = (r_i == IDX_W'(ga)) && (r_j == IDX_W'(gb));
        assign w_adj[ga][gb]  = r_pair_hit[P];
      end else if (ga > gb) begin : g_lower
        localparam int P = pair_index(gb, ga, NUM_OBJ);
        assign w_adj[ga][gb]  = r_pair_hit[P];
      end else begin : g_diag
        assign w_adj[ga][gb]  = 1'b0;
      end
    end
    assign obj_hit[ga] = |w_adj[ga];
  end

  assign pair_hit = r_pair_hit;
  assign any_hit  = |r_pair_hit;

endmodule
`default_nettype wire

// File: doc/sat_collision_engine.md
Name: sat_collision_engine

Overview:
- Sequential separating-axis-theorem (SAT) collision engine for up to NUM_OBJ oriented rectangles held in an internal object table.
- On `start`, it scans every unordered pair (i<j) and tests the 4 candidate axes (uA, vA, uB, vB), one axis per cycle, exiting early once an axis separates the pair.
- Results go to per-pair, per-object and global hit outputs.
- It is the multi-object successor of the single-pair combinational detector and sits between the physics update and the game-logic response stage.

Parameters:
- NUM_OBJ, 4, number of table entries (2..16)
- IDX_W, $clog2(NUM_OBJ), object index width
- NUM_PAIRS, NUM_OBJ*(NUM_OBJ-1)/2, number of result bits

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a scan; sampled only in IDLE
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the scan completes
- obj_wr_en  input  1  write one table entry
- obj_wr_idx  input  IDX_W  entry index
- obj_wr_active  input  1  entry participates in scans
- obj_wr_width, obj_wr_height  input  8  unsigned integer size
- obj_wr_pos_x, obj_wr_pos_y  input  32  signed Q7.25 centre
- obj_wr_u_x, obj_wr_u_y, obj_wr_v_x, obj_wr_v_y  input  16  signed Q2.14 unit basis vectors
- pair_hit  output  NUM_PAIRS  pair p colliding; p enumerates (0,1),(0,2)..(0,N-1),(1,2)..
- obj_hit  output  NUM_OBJ  OR of all pairs containing that object
- any_hit  output  1  OR of pair_hit

Behaviour:
- Reset (async assert, sync deassert):
  - FSM goes to IDLE.
  - busy=0, done=0, pair_hit/obj_hit/any_hit=0.
  - All table entries are cleared (active=0).
  - Reset during a scan aborts it; no done pulse is issued.
- Table writes:
  - Take effect on the next edge.
  - Ignored while busy, so the table is stable for the whole scan.
  - A write with obj_wr_idx >= NUM_OBJ is ignored.
- FSM states: IDLE -> FETCH -> AXIS -> WRITE -> (FETCH | FIN) -> IDLE.
- IDLE:
  - start=1 clears pair_hit (and therefore obj_hit/any_hit), sets i=0, j=1 and moves to FETCH.
  - start while busy is ignored.
- FETCH:
  - Registers entries i and j into pair registers A and B, and sets k=0.
  - If either entry is inactive, the pair result is 0 and the FSM advances directly to the next pair, or to FIN after the last pair (1 cycle total).
- AXIS: one cycle per axis k (0 = uA, 1 = vA, 2 = uB, 3 = vB).
  - d = posA - posB, signed Q7.25.
  - proj = |d.x*L.x + d.y*L.y|, Q9.39.
  - rad = hwA*|uA.L| + hhA*|vA.L| + hwB*|uB.L| + hhB*|vB.L|, with hw = width>>1 and hh = height>>1 (7-bit integers).
  - Basis dot products are Q4.28; rad is Q12.28, left-shifted 11 to Q.39.
  - Both proj and rad are sign-extended to 64-bit Q25.39 before comparison; no truncation before the compare.
  - Separated iff proj >= rad (touching counts as not colliding).
  - Separated -> WRITE with result 0. k=3 and not separated -> WRITE with result 1. Otherwise k++.
- WRITE:
  - pair_hit[p] <= result.
  - Advance j, wrapping to i+1 after N-1 and incrementing i.
  - Go to FETCH, or to FIN after pair (N-2, N-1).
- FIN: done=1 for one cycle, busy=0 in the next cycle, return to IDLE.
- Cycle budget per pair:
  - active pair: 1 + (k_sep+1) + 1 cycles, max 6
  - inactive pair: 1 cycle
- Latency: worst-case scan = 6*NUM_PAIRS + 1 cycles from the accepting start edge to done.
- Outputs:
  - obj_hit and any_hit are combinational from pair_hit.
  - All results hold until the next accepted start.

Decomposition:
- Package sat_pkg:
  - Format localparams: POS_INT=7, POS_FRAC=25, BASIS_FRAC=14, CMP_FRAC=39, CMP_W=64
  - obj_t struct: active, width, height, pos, u, v
  - state enum
  - function pair_index(i, j, N)
- Sub-module sat_axis_test: combinational. Inputs are A, B (obj_t) and axis select k; outputs are separated, plus proj/rad for debug.
- The engine owns the table, FSM and result register.

Test Plan:
- Overlapping pair: obj0 16x16 at (10,10), obj1 16x16 at (20,10), u=(0x4000,0), v=(0,0x4000), start -> pair_hit[0]=1, obj_hit=0011, any_hit=1; pair (0,1) takes 6 cycles.
- Touching edge: add obj2 16x16 at (26,10) -> pair (0,2) separates on k=0 in 3 cycles with pair_hit[1]=0; pair (1,2) hits, pair_hit[3]=1.
- Rotated case: obj2 at (20,10) with u=(0x2D41,0x2D41), v=(0xD2BF,0x2D41) against obj0 -> hit. Moving it to (32,10) -> no hit, because 22 >= 8+11.31.
- Inactive entry: obj3 active=0 -> pairs 2, 4 and 5 are 0, and each costs 1 cycle; done timing matches the cycle budget exactly.
- Handshake: start pulsed again while busy, plus a table write while busy -> both ignored; exactly one done pulse; table unchanged at the next scan.
- Reset mid-scan: assert reset_n=0 while in AXIS -> busy, done and all hit outputs 0 immediately; table is empty afterwards, and the next scan reports all zeros.
